// File: rtl/floodit_pkg.sv
// rtl/floodit_pkg.sv - shared constants, colours, engine states and cell indexing for the flood-it engine
package floodit_pkg;

    localparam int MAX_SIZE = 26;
    localparam int COLOR_W  = 3;
    localparam int CELLS    = MAX_SIZE * MAX_SIZE;
    localparam int IDX_W    = $clog2(CELLS);
    localparam int BOARD_W  = CELLS * COLOR_W;

    localparam logic [COLOR_W-1:0] COL_RED    = 3'd0;
    localparam logic [COLOR_W-1:0] COL_GREEN  = 3'd1;
    localparam logic [COLOR_W-1:0] COL_BLUE   = 3'd2;
    localparam logic [COLOR_W-1:0] COL_YELLOW = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_RECOLOR,
        ST_GROW,
        ST_CHECK,
        ST_RELEASE
    } state_e;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [4:0] r, input logic [4:0] c);
        return IDX_W'(r) * IDX_W'(MAX_SIZE) + IDX_W'(c);
    endfunction

endpackage

// File: rtl/flood_neighbor_check.sv
// rtl/flood_neighbor_check.sv - flags whether any in-range 4-neighbour of (r,c) is already in the flood region
module flood_neighbor_check
    import floodit_pkg::*;
(
    input  logic [4:0]       r,
    input  logic [4:0]       c,
    input  logic [4:0]       size,
    input  logic [CELLS-1:0] mask,
    output logic             nbr_masked
);

    // Edge guards stop row ends from wrapping into the next row of the flat mask.
    always_comb begin
        nbr_masked = 1'b0;
        if (r != 5'd0)
            nbr_masked = nbr_masked | mask[cell_idx(r - 5'd1, c)];
        if (r + 5'd1 < size)
            nbr_masked = nbr_masked | mask[cell_idx(r + 5'd1, c)];
        if (c != 5'd0)
            nbr_masked = nbr_masked | mask[cell_idx(r, c - 5'd1)];
        if (c + 5'd1 < size)
            nbr_masked = nbr_masked | mask[cell_idx(r, c + 5'd1)];
    end

endmodule

// File: rtl/flood_fill_engine.sv
// rtl/flood_fill_engine.sv - live flood-it board: colour-move handshake, recolour and raster region growth
module flood_fill_engine
    import floodit_pkg::*;
(
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                LOAD,
    input  logic [BOARD_W-1:0]  INIT_BOARD,
    input  logic [4:0]          SIZE,
    input  logic                COLOR_SEL_SIG,
    input  logic [COLOR_W-1:0]  COLOR_SELECTED,
    output logic                CHANGING_COLOR,
    output logic [BOARD_W-1:0]  GAME_BOARD,
    output logic [7:0]          MOVES,
    output logic                WON
);

    state_e               state_q, state_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic [CELLS-1:0]     mask_q, mask_d;
    logic [4:0]           size_q, size_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [4:0]           row_q, row_d;
    logic [4:0]           col_q, col_d;
    logic                 changed_q, changed_d;
    logic [7:0]           moves_q, moves_d;
    logic                 won_q, won_d;
    logic                 ack_q, ack_d;

    logic                 nbr_masked;
    logic [IDX_W-1:0]     idx;
    logic [COLOR_W-1:0]   cur_col;
    logic                 last_cell;
    logic                 join_cell;
    logic                 all_masked;

    flood_neighbor_check u_nbr (
        .r          (row_q),
        .c          (col_q),
        .size       (size_q),
        .mask       (mask_q),
        .nbr_masked (nbr_masked)
    );

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        mask_d    = mask_q;
        size_d    = size_q;
        color_d   = color_q;
        row_d     = row_q;
        col_d     = col_q;
        changed_d = changed_q;
        moves_d   = moves_q;
        won_d     = won_q;
        ack_d     = ack_q;

        idx       = cell_idx(row_q, col_q);
        cur_col   = board_q[int'(idx)*COLOR_W +: COLOR_W];
        last_cell = (row_q == size_q - 5'd1) && (col_q == size_q - 5'd1);
        join_cell = !mask_q[idx] && (cur_col == color_q) && nbr_masked;

        all_masked = 1'b1;
        for (int r = 0; r < MAX_SIZE; r++) begin
            for (int c = 0; c < MAX_SIZE; c++) begin
                if (5'(r) < size_q && 5'(c) < size_q && !mask_q[r*MAX_SIZE + c])
                    all_masked = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (COLOR_SEL_SIG && !ack_q) begin
                    ack_d   = 1'b1;
                    color_d = COLOR_SELECTED;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (color_q == board_q[COLOR_W-1:0] || won_q)
                    state_d = ST_RELEASE;
                else
                    state_d = ST_RECOLOR;
            end
            ST_RECOLOR: begin
                for (int i = 0; i < CELLS; i++) begin
                    if (mask_q[i])
                        board_d[i*COLOR_W +: COLOR_W] = color_q;
                end
                moves_d   = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
                row_d     = 5'd0;
                col_d     = 5'd0;
                changed_d = 1'b0;
                state_d   = ST_GROW;
            end
            ST_GROW: begin
                if (join_cell)
                    mask_d[idx] = 1'b1;
                if (last_cell) begin
                    row_d     = 5'd0;
                    col_d     = 5'd0;
                    changed_d = 1'b0;
                    if (!(changed_q || join_cell))
                        state_d = ST_CHECK;
                end else begin
                    changed_d = changed_q | join_cell;
                    if (col_q == size_q - 5'd1) begin
                        col_d = 5'd0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            ST_CHECK: begin
                won_d   = won_q | all_masked;
                // A grow started by LOAD with no open handshake has nothing to release.
                state_d = ack_q ? ST_RELEASE : ST_IDLE;
            end
            ST_RELEASE: begin
                if (!COLOR_SEL_SIG) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (LOAD) begin
            board_d   = INIT_BOARD;
            size_d    = (SIZE < 5'd2) ? 5'd2 : (SIZE > 5'(MAX_SIZE)) ? 5'(MAX_SIZE) : SIZE;
            moves_d   = 8'd0;
            won_d     = 1'b0;
            mask_d    = {{(CELLS-1){1'b0}}, 1'b1};
            color_d   = INIT_BOARD[COLOR_W-1:0];
            row_d     = 5'd0;
            col_d     = 5'd0;
            changed_d = 1'b0;
            ack_d     = ack_q & COLOR_SEL_SIG;
            state_d   = ST_GROW;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            board_q   <= '0;
            mask_q    <= '0;
            size_q    <= 5'd2;
            color_q   <= '0;
            row_q     <= 5'd0;
            col_q     <= 5'd0;
            changed_q <= 1'b0;
            moves_q   <= 8'd0;
            won_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            mask_q    <= mask_d;
            size_q    <= size_d;
            color_q   <= color_d;
            row_q     <= row_d;
            col_q     <= col_d;
            changed_q <= changed_d;
            moves_q   <= moves_d;
            won_q     <= won_d;
            ack_q     <= ack_d;
        end
    end

    assign CHANGING_COLOR = ack_q;
    assign GAME_BOARD     = board_q;
    assign MOVES          = moves_q;
    assign WON            = won_q;

endmodule
